// File: rtl/box_arb_pkg.sv
// Shared types and constants for the two-requester register-box arbiter.
// The WAIT-state timeout is enabled with the BOX_ARB_TIMEOUT_EN macro.
package box_arb_pkg;

  localparam int unsigned DefDataW      = 8;
  localparam int unsigned DefAddrW      = 2;
  localparam int unsigned TimeoutCycles = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } box_arb_state_e;

endpackage

// File: rtl/box_arb_rr.sv
// Two-way round-robin picker: a lone request wins outright, and under contention
// the requester that was not served last wins.
module box_arb_rr (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_win
);

  always_comb begin
    o_win = i_req;
    if (i_req == 2'b11) begin
      o_win = i_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/box_arbiter.sv
// Arbitrates two requesters onto a single register box, one command at a time.
// Define BOX_ARB_TIMEOUT_EN to bound the read wait and report err on expiry.
module box_arbiter
  import box_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          err,
  output logic                box_read_enable,
  output logic                box_write_enable,
  output logic [ADDR_W-1:0]   box_address,
  output logic [DATA_W-1:0]   box_write_data,
  input  logic [DATA_W-1:0]   box_read_data,
  input  logic                box_read_active
);

  box_arb_state_e r_state, w_state_d;
  logic [1:0]        r_owner, w_owner_d;
  logic              r_op_we, w_op_we_d;
  logic              r_last, w_last_d;
  logic [1:0]        r_gnt, w_gnt_d;
  logic [1:0]        r_done, w_done_d;
  logic [1:0]        r_err, w_err_d;
  logic [DATA_W-1:0] r_rdata, w_rdata_d;
  logic              r_box_re, w_box_re_d;
  logic              r_box_we, w_box_we_d;
  logic [ADDR_W-1:0] r_box_addr, w_box_addr_d;
  logic [DATA_W-1:0] r_box_wdata, w_box_wdata_d;
  logic [1:0]        w_win;

`ifdef BOX_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles);
  logic [CntW-1:0] r_cnt, w_cnt_d;
`endif

  box_arb_rr u_rr (
    .i_req  (req),
    .i_last (r_last),
    .o_win  (w_win)
  );

  always_comb begin
    w_state_d     = r_state;
    w_owner_d     = r_owner;
    w_op_we_d     = r_op_we;
    w_last_d      = r_last;
    w_gnt_d       = 2'b00;
    w_done_d      = 2'b00;
    w_err_d       = 2'b00;
    w_rdata_d     = r_rdata;
    w_box_re_d    = 1'b0;
    w_box_we_d    = 1'b0;
    w_box_addr_d  = r_box_addr;
    w_box_wdata_d = r_box_wdata;
`ifdef BOX_ARB_TIMEOUT_EN
    w_cnt_d       = r_cnt;
`endif
    unique case (r_state)
      StIdle: begin
        if (req != 2'b00) begin
          w_state_d     = StIssue;
          w_owner_d     = w_win;
          w_gnt_d       = w_win;
          w_op_we_d     = w_win[1] ? we[1] : we[0];
          w_box_we_d    = w_op_we_d;
          w_box_re_d    = ~w_op_we_d;
          w_box_addr_d  = w_win[1] ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
          w_box_wdata_d = w_win[1] ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
        end
      end
      StIssue: begin
        w_gnt_d = r_owner;
        if (r_op_we) begin
          w_state_d = StDone;
          w_done_d  = r_owner;
        end else begin
          w_state_d = StWait;
`ifdef BOX_ARB_TIMEOUT_EN
          w_cnt_d   = '0;
`endif
        end
      end
      StWait: begin
        w_gnt_d = r_owner;
        if (box_read_active) begin
          w_state_d = StDone;
          w_done_d  = r_owner;
          w_rdata_d = box_read_data;
        end
`ifdef BOX_ARB_TIMEOUT_EN
        else if (r_cnt == CntW'(TimeoutCycles - 1)) begin
          // Give up on the box; rdata keeps its previous value.
          w_state_d = StDone;
          w_done_d  = r_owner;
          w_err_d   = r_owner;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
`endif
      end
      StDone: begin
        w_state_d = StIdle;
        w_last_d  = r_owner[1];
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_owner     <= 2'b00;
      r_op_we     <= 1'b0;
      r_last      <= 1'b1;  // requester 0 wins the first contention
      r_gnt       <= 2'b00;
      r_done      <= 2'b00;
      r_err       <= 2'b00;
      r_rdata     <= '0;
      r_box_re    <= 1'b0;
      r_box_we    <= 1'b0;
      r_box_addr  <= '0;
      r_box_wdata <= '0;
`ifdef BOX_ARB_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_owner     <= w_owner_d;
      r_op_we     <= w_op_we_d;
      r_last      <= w_last_d;
      r_gnt       <= w_gnt_d;
      r_done      <= w_done_d;
      r_err       <= w_err_d;
      r_rdata     <= w_rdata_d;
      r_box_re    <= w_box_re_d;
      r_box_we    <= w_box_we_d;
      r_box_addr  <= w_box_addr_d;
      r_box_wdata <= w_box_wdata_d;
`ifdef BOX_ARB_TIMEOUT_EN
      r_cnt       <= w_cnt_d;
`endif
    end
  end

  assign gnt              = r_gnt;
  assign done             = r_done;
  assign err              = r_err;
  assign rdata            = r_rdata;
  assign box_read_enable  = r_box_re;
  assign box_write_enable = r_box_we;
  assign box_address      = r_box_addr;
  assign box_write_data   = r_box_wdata;

endmodule
